guess_entry: RTL and testbench

- Player-facing guess composer for the code-breaking game.
- Turns button presses into a 4-peg guess (3-bit colour per peg) and commits it to the history block.
- Drives history's guess0..guess3 and btn_select (via commit), and stops on history's end_game.
- It is the writer side of the guess/commit interface that history reads.

---
 rtl/guess_entry.sv | 118 +++++++++++
 tb/tb_guess_entry.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// rtl/guess_entry.sv - button-driven 4-peg guess composer with commit pulse and lockout
module guess_entry #(
    parameter int NUM_COLORS = 6,
    parameter int MAX_TURNS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_select,
    input  logic       end_game,
    output logic [2:0] guess0,
    output logic [2:0] guess1,
    output logic [2:0] guess2,
    output logic [2:0] guess3,
    output logic [1:0] cursor,
    output logic       commit,
    output logic [2:0] turn_count,
    output logic       locked
);

    typedef enum logic [1:0] {
        ST_EDIT,
        ST_COMMIT,
        ST_LOCKED
    } state_t;

    localparam logic [2:0] TOP_COLOR  = 3'(NUM_COLORS - 1);
    localparam logic [3:0] TURN_LIMIT = 4'(MAX_TURNS);

    state_t     state, state_n;
    logic [2:0] peg   [4];
    logic [2:0] peg_n [4];
    logic [1:0] cur, cur_n;
    logic [3:0] cnt, cnt_n;
    logic [4:0] btn, btn_prev, press;

    // Bit order: {select, down, up, right, left}
    assign btn   = {btn_select, btn_down, btn_up, btn_right, btn_left};
    assign press = btn & ~btn_prev;

    function automatic logic [2:0] col_up(input logic [2:0] c);
        return (c == TOP_COLOR) ? 3'd0 : c + 3'd1;
    endfunction

    function automatic logic [2:0] col_down(input logic [2:0] c);
        return (c == 3'd0) ? TOP_COLOR : c - 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_EDIT;
            peg      <= '{default: 3'd0};
            cur      <= 2'd0;
            cnt      <= 4'd0;
            btn_prev <= 5'b11111;
        end else begin
            state    <= state_n;
            peg      <= peg_n;
            cur      <= cur_n;
            cnt      <= cnt_n;
            btn_prev <= btn;
        end
    end

    always_comb begin
        state_n = state;
        peg_n   = peg;
        cur_n   = cur;
        cnt_n   = cnt;
        case (state)
            ST_EDIT: begin
                if (end_game) begin
                    state_n = ST_LOCKED;
                end else if (!mode) begin
                    if (press[4]) begin
                        state_n = ST_COMMIT;
                    end else begin
                        if (press[1] && !press[0]) begin
                            cur_n = cur + 2'd1;
                        end else if (press[0] && !press[1]) begin
                            cur_n = cur - 2'd1;
                        end
                        // Colour edit targets the cursor position before any same-edge move
                        if (press[2] && !press[3]) begin
                            peg_n[cur] = col_up(peg[cur]);
                        end else if (press[3] && !press[2]) begin
                            peg_n[cur] = col_down(peg[cur]);
                        end
                    end
                end
            end
            ST_COMMIT: begin
                cnt_n   = cnt + 4'd1;
                cur_n   = 2'd0;
                state_n = (cnt_n == TURN_LIMIT || end_game) ? ST_LOCKED : ST_EDIT;
            end
            ST_LOCKED: begin
            end
            default: begin
                state_n = ST_EDIT;
            end
        endcase
    end

    assign guess0     = peg[0];
    assign guess1     = peg[1];
    assign guess2     = peg[2];
    assign guess3     = peg[3];
    assign cursor     = cur;
    assign commit     = (state == ST_COMMIT);
    assign locked     = (state == ST_LOCKED);
    assign turn_count = cnt[2:0];

endmodule

// File: tb/tb_guess_entry.sv
// tb/tb_guess_entry.sv - directed table, corner sequences and random model check for guess_entry
module tb_guess_entry;

    localparam int NC = 6;
    localparam int MT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, mode, btn_left, btn_right, btn_up, btn_down, btn_select, end_game;
    logic [2:0] guess0, guess1, guess2, guess3;
    logic [1:0] cursor;
    logic       commit;
    logic [2:0] turn_count;
    logic       locked;

    guess_entry #(.NUM_COLORS(NC), .MAX_TURNS(MT)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_select(btn_select), .end_game(end_game),
        .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
        .cursor(cursor), .commit(commit), .turn_count(turn_count), .locked(locked)
    );

    typedef struct packed {
        logic [7:0]  in;   // {reset, mode, left, right, up, down, select, end_game}
        logic [18:0] exp;  // {g3, g2, g1, g0, cursor, commit, locked, turn_count}
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: peg colours as integers, game phase 0=edit 1=commit 2=locked
    int         mg [4];
    int         mcur, mcnt, mst;
    logic [4:0] mprev;

    function automatic logic [18:0] obs();
        return {guess3, guess2, guess1, guess0, cursor, commit, locked, turn_count};
    endfunction

    function automatic logic [18:0] model_vec();
        return {3'(mg[3]), 3'(mg[2]), 3'(mg[1]), 3'(mg[0]), 2'(mcur),
                (mst == 1), (mst == 2), 3'(mcnt % 8)};
    endfunction

    function automatic vec_t mk(input logic [7:0] in, input logic [11:0] g, input logic [1:0] c,
                                input logic com, input logic lck, input logic [2:0] tc);
        vec_t v;
        v.in  = in;
        v.exp = {g, c, com, lck, tc};
        return v;
    endfunction

    task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_step();
        logic [4:0] b, p;
        int old;
        b = {btn_select, btn_down, btn_up, btn_right, btn_left};
        if (!reset) begin
            for (int i = 0; i < 4; i++) mg[i] = 0;
            mcur  = 0;
            mcnt  = 0;
            mst   = 0;
            mprev = 5'b11111;
        end else begin
            p     = b & ~mprev;
            mprev = b;
            case (mst)
                0: begin
                    if (end_game) mst = 2;
                    else if (!mode) begin
                        if (p[4]) mst = 1;
                        else begin
                            old      = mcur;
                            mcur     = (mcur + int'(p[1]) - int'(p[0]) + 4) % 4;
                            mg[old]  = (mg[old] + int'(p[2]) - int'(p[3]) + NC) % NC;
                        end
                    end
                end
                1: begin
                    mcnt = mcnt + 1;
                    mcur = 0;
                    mst  = (mcnt == MT || end_game) ? 2 : 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic set_in(input logic [7:0] v);
        {reset, mode, btn_left, btn_right, btn_up, btn_down, btn_select, end_game} = v;
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        m_step();
        #1;
        chk({name, " model"}, obs(), model_vec());
    endtask

    localparam logic [7:0] NONE = 8'b1000_0000;
    localparam logic [7:0] L    = 8'b1010_0000;
    localparam logic [7:0] R    = 8'b1001_0000;
    localparam logic [7:0] U    = 8'b1000_1000;
    localparam logic [7:0] D    = 8'b1000_0100;
    localparam logic [7:0] S    = 8'b1000_0010;
    localparam logic [7:0] RU   = 8'b1001_1000;

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < 4; i++) mg[i] = 0;
        mcur = 0; mcnt = 0; mst = 0; mprev = 5'b11111;
        set_in(8'b0);

        tbl.push_back(mk(8'b0,  12'o0000, 0, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o0000, 0, 0, 0, 0));
        tbl.push_back(mk(L,     12'o0000, 3, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o0000, 3, 0, 0, 0));
        tbl.push_back(mk(D,     12'o5000, 3, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o5000, 3, 0, 0, 0));
        tbl.push_back(mk(U,     12'o0000, 3, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o0000, 3, 0, 0, 0));
        tbl.push_back(mk(RU,    12'o1000, 0, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o1000, 0, 0, 0, 0));
        tbl.push_back(mk(U,     12'o1001, 0, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o1001, 0, 0, 0, 0));
        tbl.push_back(mk(R,     12'o1001, 1, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o1001, 1, 0, 0, 0));
        tbl.push_back(mk(U,     12'o1011, 1, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o1011, 1, 0, 0, 0));
        tbl.push_back(mk(RU,    12'o1021, 2, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o1021, 2, 0, 0, 0));
        tbl.push_back(mk(U,     12'o1121, 2, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o1121, 2, 0, 0, 0));
        tbl.push_back(mk(U,     12'o1221, 2, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o1221, 2, 0, 0, 0));
        tbl.push_back(mk(RU,    12'o1321, 3, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o1321, 3, 0, 0, 0));
        tbl.push_back(mk(U,     12'o2321, 3, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o2321, 3, 0, 0, 0));
        tbl.push_back(mk(U,     12'o3321, 3, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o3321, 3, 0, 0, 0));
        tbl.push_back(mk(U,     12'o4321, 3, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o4321, 3, 0, 0, 0));
        tbl.push_back(mk(8'b1011_0000, 12'o4321, 3, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o4321, 3, 0, 0, 0));
        tbl.push_back(mk(8'b1000_1100, 12'o4321, 3, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o4321, 3, 0, 0, 0));
        tbl.push_back(mk(S,     12'o4321, 3, 1, 0, 0));
        tbl.push_back(mk(NONE,  12'o4321, 0, 0, 0, 1));
        tbl.push_back(mk(8'b1000_1010, 12'o4321, 0, 1, 0, 1));
        tbl.push_back(mk(NONE,  12'o4321, 0, 0, 0, 2));
        tbl.push_back(mk(8'b1100_1000, 12'o4321, 0, 0, 0, 2));
        tbl.push_back(mk(8'b1100_0000, 12'o4321, 0, 0, 0, 2));
        tbl.push_back(mk(8'b1100_0010, 12'o4321, 0, 0, 0, 2));
        tbl.push_back(mk(S,     12'o4321, 0, 0, 0, 2));
        tbl.push_back(mk(NONE,  12'o4321, 0, 0, 0, 2));
        tbl.push_back(mk(8'b1000_0001, 12'o4321, 0, 0, 1, 2));
        tbl.push_back(mk(U,     12'o4321, 0, 0, 1, 2));
        tbl.push_back(mk(8'b0,  12'o0000, 0, 0, 0, 0));
        tbl.push_back(mk(NONE,  12'o0000, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].in);
            tick($sformatf("row%0d", i));
            chk($sformatf("row%0d table", i), obs(), tbl[i].exp);
        end

        // Right held across reset release must not register as a press
        set_in(8'b0001_0000);
        tick("hold_reset");
        set_in(R);
        repeat (5) tick("hold_right");
        chk("held_right_cursor", 19'(cursor), 19'd0);
        set_in(NONE);
        tick("release_right");
        set_in(R);
        tick("press_right");
        chk("press_after_release_cursor", 19'(cursor), 19'd1);

        // Eight commits reach lockout; 3-bit count reads back as 8 mod 8
        set_in(8'b0);
        tick("turns_reset");
        set_in(NONE);
        tick("turns_idle");
        for (int k = 0; k < MT; k++) begin
            set_in(S);
            tick("turn_select");
            chk($sformatf("turn%0d_commit", k), 19'(commit), 19'd1);
            set_in(NONE);
            tick("turn_release");
        end
        chk("lock_after_max", 19'(locked), 19'd1);
        chk("lock_turn_count", 19'(turn_count), 19'(MT % 8));
        set_in(S);
        tick("extra_select");
        chk("no_commit_when_locked", 19'(commit), 19'd0);

        // Reset landing on the commit cycle
        set_in(8'b0);
        tick("rc_reset");
        set_in(NONE);
        tick("rc_idle");
        set_in(S);
        tick("rc_select");
        chk("rc_commit_high", 19'(commit), 19'd1);
        set_in(8'b0);
        tick("rc_reset_in_commit");
        chk("rc_all_zero", obs(), 19'd0);
        set_in(NONE);
        tick("rc_after");
        chk("rc_no_increment", {16'd0, turn_count}, 19'd0);

        for (int n = 0; n < 800; n++) begin
            set_in({($urandom_range(39) != 0), ($urandom_range(4) == 0),
                    ($urandom_range(2) == 0), ($urandom_range(2) == 0),
                    ($urandom_range(2) == 0), ($urandom_range(2) == 0),
                    ($urandom_range(2) == 0), ($urandom_range(59) == 0)});
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
